// File: rtl/instruction_fetch_queue_pkg.sv
// ============================================================================
// instruction_fetch_queue_pkg: fetch address constants shared by the fetch stage
// Rev 1.0
// ============================================================================
`default_nettype none

package instruction_fetch_queue_pkg;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;
    localparam int unsigned PC_INC         = 4;
    localparam int unsigned ALIGN_MASK     = 3;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// fetch_fifo: synchronous FIFO with clear, occupancy count and registered head
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    input  logic [WIDTH-1:0] wdata,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // A full FIFO still accepts a write when the head leaves in the same cycle
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_queue.sv
// ============================================================================
// instruction_fetch_queue: pipelined instruction fetch with credit-limited
// prefetch queue, redirect/flush handling and stale-response discard
// Rev 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_queue
    import instruction_fetch_queue_pkg::*;
#(
    parameter int IWIDTH          = 32,
    parameter int AWIDTH_INSTR    = 32,
    parameter int PC_WIDTH        = 32,
    parameter int DEPTH           = 4,
    parameter int MAX_OUTSTANDING = 2,
    parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(FETCH_RESET_PC)
) (
    input  logic                    f_clk,
    input  logic                    f_rst,
    input  logic                    f_i_ce,
    output logic                    f_o_syn,
    output logic [AWIDTH_INSTR-1:0] f_o_addr_instr,
    input  logic                    f_i_gnt,
    input  logic                    f_i_ack,
    input  logic [IWIDTH-1:0]       f_i_instr,
    input  logic                    f_change_pc,
    input  logic [PC_WIDTH-1:0]     f_alu_pc_value,
    input  logic                    f_i_flush,
    input  logic                    f_i_stall,
    output logic                    f_o_ce,
    output logic [IWIDTH-1:0]       f_o_instr,
    output logic [PC_WIDTH-1:0]     f_pc,
    output logic                    f_o_flush
);

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int TW  = $clog2(MAX_OUTSTANDING + 1);

    logic [PC_WIDTH-1:0] fpc_q, fpc_d;
    logic [CW-1:0]       discard_q, discard_d;
    logic                syn_q, syn_d;
    logic                halt_q, halt_d;
    logic                flush_q, flush_d;

    logic                grant, pop, redirect, ack_keep;
    logic [CW-1:0]       outstanding, out_next, occ_next;
    logic [TW-1:0]       tag_count;
    logic [PC_WIDTH-1:0] tag_head;
    logic [CW-1:0]       data_count;
    logic [IWIDTH+PC_WIDTH-1:0] data_head;

    always_comb begin
        grant       = syn_q && f_i_gnt;
        pop         = f_o_ce && !f_i_stall;
        redirect    = f_change_pc || f_i_flush;
        ack_keep    = f_i_ack && (discard_q == '0) && !redirect;
        outstanding = CW'(tag_count);
        out_next    = outstanding + CW'(grant) - CW'(f_i_ack);
        occ_next    = redirect ? '0 : data_count + CW'(ack_keep) - CW'(pop);

        halt_d = halt_q;
        if (f_change_pc) begin
            halt_d = 1'b0;
        end else if (f_i_flush) begin
            halt_d = 1'b1;
        end

        // Every request still in flight at a redirect returns stale data
        discard_d = discard_q;
        if (redirect) begin
            discard_d = out_next;
        end else if (f_i_ack && (discard_q != '0)) begin
            discard_d = discard_q - CW'(1);
        end

        fpc_d = fpc_q;
        if (f_change_pc) begin
            fpc_d = f_alu_pc_value & ~PC_WIDTH'(ALIGN_MASK);
        end else if (grant) begin
            fpc_d = fpc_q + PC_WIDTH'(PC_INC);
        end

        // Credits count both in-flight reads and queued words so every ack has a slot
        syn_d = (syn_q && !f_i_gnt && !redirect) ||
                (f_i_ce && !halt_d &&
                 (out_next < CW'(MAX_OUTSTANDING)) &&
                 ((CW1'(out_next) + CW1'(occ_next)) < CW1'(DEPTH)));

        flush_d = redirect;
    end

    always_ff @(posedge f_clk or negedge f_rst) begin
        if (!f_rst) begin
            fpc_q     <= RESET_PC;
            discard_q <= '0;
            syn_q     <= 1'b0;
            halt_q    <= 1'b0;
            flush_q   <= 1'b0;
        end else begin
            fpc_q     <= fpc_d;
            discard_q <= discard_d;
            syn_q     <= syn_d;
            halt_q    <= halt_d;
            flush_q   <= flush_d;
        end
    end

    fetch_fifo #(
        .WIDTH (PC_WIDTH),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk   (f_clk),
        .rst_n (f_rst),
        .push  (grant),
        .pop   (f_i_ack),
        .clear (1'b0),
        .wdata (fpc_q),
        .count (tag_count),
        .head  (tag_head)
    );

    fetch_fifo #(
        .WIDTH (IWIDTH + PC_WIDTH),
        .DEPTH (DEPTH)
    ) u_data_fifo (
        .clk   (f_clk),
        .rst_n (f_rst),
        .push  (ack_keep),
        .pop   (pop),
        .clear (redirect),
        .wdata ({f_i_instr, tag_head}),
        .count (data_count),
        .head  (data_head)
    );

    assign f_o_syn          = syn_q;
    assign f_o_addr_instr   = AWIDTH_INSTR'(fpc_q);
    assign f_o_ce           = (data_count != '0);
    assign {f_o_instr, f_pc} = data_head;
    assign f_o_flush        = flush_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_queue.sv
// ============================================================================
// tb_instruction_fetch_queue: directed self-checking bench for the fetch queue
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_queue;

    logic        f_clk          = 1'b0;
    logic        f_rst          = 1'b0;
    logic        f_i_ce         = 1'b0;
    logic        f_i_gnt        = 1'b0;
    logic        f_i_ack        = 1'b0;
    logic [31:0] f_i_instr      = 32'h0;
    logic        f_change_pc    = 1'b0;
    logic [31:0] f_alu_pc_value = 32'h0;
    logic        f_i_flush      = 1'b0;
    logic        f_i_stall      = 1'b0;
    logic        f_o_syn;
    logic [31:0] f_o_addr_instr;
    logic        f_o_ce;
    logic [31:0] f_o_instr;
    logic [31:0] f_pc;
    logic        f_o_flush;

    int          n_chk   = 0;
    int          n_pass  = 0;
    int          n_grant = 0;
    int          n_pop   = 0;
    logic        ack_en  = 1'b0;
    logic        cons_en = 1'b0;
    logic [31:0] exp_pc  = 32'h0;
    logic [31:0] pend[$];
    logic [31:0] stall_head;

    instruction_fetch_queue dut (
        .f_clk          (f_clk),
        .f_rst          (f_rst),
        .f_i_ce         (f_i_ce),
        .f_o_syn        (f_o_syn),
        .f_o_addr_instr (f_o_addr_instr),
        .f_i_gnt        (f_i_gnt),
        .f_i_ack        (f_i_ack),
        .f_i_instr      (f_i_instr),
        .f_change_pc    (f_change_pc),
        .f_alu_pc_value (f_alu_pc_value),
        .f_i_flush      (f_i_flush),
        .f_i_stall      (f_i_stall),
        .f_o_ce         (f_o_ce),
        .f_o_instr      (f_o_instr),
        .f_pc           (f_pc),
        .f_o_flush      (f_o_flush)
    );

    always #5 f_clk = ~f_clk;

    // Memory: responds in order one cycle after each grant, data = ~address
    always @(posedge f_clk) begin
        if (!f_rst) begin
            pend.delete();
        end else if (f_o_syn && f_i_gnt) begin
            pend.push_back(f_o_addr_instr);
            n_grant++;
        end
        #1;
        if (f_rst && ack_en && pend.size() > 0) begin
            f_i_ack   = 1'b1;
            f_i_instr = ~pend.pop_front();
        end else begin
            f_i_ack   = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge f_clk);
        #2;
    endtask

    task automatic wait_ce(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge f_clk);
            if (f_o_ce) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_syn"},   32'(f_o_syn),   32'd0);
        chk({tag, "_addr"},  f_o_addr_instr, 32'h0);
        chk({tag, "_ce"},    32'(f_o_ce),    32'd0);
        chk({tag, "_instr"}, f_o_instr,      32'h0);
        chk({tag, "_pc"},    f_pc,           32'h0);
        chk({tag, "_flush"}, 32'(f_o_flush), 32'd0);
    endtask

    initial begin
        // Decode side: checks every popped word against the expected PC sequence
        fork
            forever begin
                @(negedge f_clk);
                if (cons_en && f_rst && f_o_ce && !f_i_stall) begin
                    chk("pop_pc", f_pc, exp_pc);
                    chk("pop_instr", f_o_instr, ~exp_pc);
                    exp_pc = exp_pc + 32'd4;
                    n_pop++;
                end
            end
        join_none

        repeat (2) @(negedge f_clk);
        chk_reset_state("rst");

        step();
        f_rst = 1'b1; f_i_ce = 1'b1; f_i_gnt = 1'b1; ack_en = 1'b1; cons_en = 1'b1;
        @(negedge f_clk);
        chk("syn_before_edge", 32'(f_o_syn), 32'd0);
        @(negedge f_clk);
        chk("first_syn", 32'(f_o_syn), 32'd1);
        chk("first_addr", f_o_addr_instr, 32'h0);
        repeat (12) @(negedge f_clk);
        chk("stream_progress", 32'(n_pop >= 8), 32'd1);

        // Decode stall: queue fills to DEPTH and requests stop
        step();
        f_i_stall = 1'b1;
        @(negedge f_clk);
        stall_head = exp_pc;
        repeat (10) @(negedge f_clk);
        chk("stall_syn", 32'(f_o_syn), 32'd0);
        chk("stall_ce", 32'(f_o_ce), 32'd1);
        chk("stall_head", f_pc, stall_head);
        chk("stall_buffered", 32'(n_grant - n_pop), 32'd4);
        step();
        f_i_stall = 1'b0;
        repeat (8) @(negedge f_clk);

        // Redirect with two reads in flight
        step();
        ack_en = 1'b0;
        repeat (6) @(negedge f_clk);
        chk("inflight_blocked_syn", 32'(f_o_syn), 32'd0);
        chk("inflight_drained_ce", 32'(f_o_ce), 32'd0);
        step();
        f_change_pc = 1'b1; f_alu_pc_value = 32'h100;
        step();
        f_change_pc = 1'b0; exp_pc = 32'h100;
        @(negedge f_clk);
        chk("redir_flush", 32'(f_o_flush), 32'd1);
        chk("redir_ce", 32'(f_o_ce), 32'd0);
        chk("redir_addr", f_o_addr_instr, 32'h100);
        step();
        ack_en = 1'b1;
        @(negedge f_clk);
        chk("redir_flush_one_cycle", 32'(f_o_flush), 32'd0);
        wait_ce("redir_first_timeout");
        chk("redir_first_pc", f_pc, 32'h100);
        chk("redir_first_instr", f_o_instr, ~32'h100);

        // Misaligned target
        repeat (4) @(negedge f_clk);
        step();
        f_change_pc = 1'b1; f_alu_pc_value = 32'h203;
        step();
        f_change_pc = 1'b0; exp_pc = 32'h200;
        @(negedge f_clk);
        chk("align_addr", f_o_addr_instr, 32'h200);
        wait_ce("align_timeout");
        chk("align_first_pc", f_pc, 32'h200);
        repeat (8) @(negedge f_clk);

        // Flush halts fetch until the next redirect
        step();
        f_i_flush = 1'b1;
        step();
        f_i_flush = 1'b0;
        @(negedge f_clk);
        chk("flush_pulse", 32'(f_o_flush), 32'd1);
        chk("flush_ce", 32'(f_o_ce), 32'd0);
        chk("flush_syn", 32'(f_o_syn), 32'd0);
        repeat (6) @(negedge f_clk);
        chk("halt_syn", 32'(f_o_syn), 32'd0);
        chk("halt_ce", 32'(f_o_ce), 32'd0);

        // Flush and redirect together: the redirect wins
        step();
        f_i_flush = 1'b1; f_change_pc = 1'b1; f_alu_pc_value = 32'h400;
        step();
        f_i_flush = 1'b0; f_change_pc = 1'b0; exp_pc = 32'h400;
        @(negedge f_clk);
        chk("resume_addr", f_o_addr_instr, 32'h400);
        chk("resume_syn", 32'(f_o_syn), 32'd1);
        wait_ce("resume_timeout");
        chk("resume_first_pc", f_pc, 32'h400);
        repeat (6) @(negedge f_clk);

        // Asynchronous reset while the queue is loaded
        step();
        f_i_stall = 1'b1;
        repeat (8) @(negedge f_clk);
        chk("prereset_ce", 32'(f_o_ce), 32'd1);
        #3;
        f_rst = 1'b0;
        #1;
        chk_reset_state("async_rst");
        f_i_stall = 1'b0;
        step();
        f_rst = 1'b1; exp_pc = 32'h0;
        @(negedge f_clk);
        chk("restart_syn_low", 32'(f_o_syn), 32'd0);
        @(negedge f_clk);
        chk("restart_syn", 32'(f_o_syn), 32'd1);
        chk("restart_addr", f_o_addr_instr, 32'h0);
        wait_ce("restart_timeout");
        chk("restart_first_pc", f_pc, 32'h0);
        repeat (6) @(negedge f_clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
